// File: rtl/ibus_responder_pkg.sv
// Shared defines for the instruction-bus responder: default memory region,
// wait-state counter width and the saturating statistics helper.
package ibus_responder_pkg;

    // Default instruction region starts at the CPU reset vector.
    localparam logic [31:0] CPU_RESET_ADDR   = 32'h0000_0000;
    localparam int          IBUS_DEPTH_WORDS = 4096;

    // Width of the wait-state counter; WAIT_CYCLES must fit (0..7).
    localparam int          IBUS_WAIT_W      = 3;

    localparam logic [31:0] STAT_MAX         = 32'hFFFF_FFFF;

    // Increment that sticks at the top value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == STAT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ibus_wait_ctr.sv
// Wait-state counter: counts non-busy cycles of a held request and signals
// ready once WAIT_CYCLES of them have elapsed.
module ibus_wait_ctr
    import ibus_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
)(
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic busy,
    input  logic gnt,
    output logic ready
);

    localparam logic [IBUS_WAIT_W-1:0] LP_WAIT = IBUS_WAIT_W'(WAIT_CYCLES);

    logic [IBUS_WAIT_W-1:0] r_wait_cnt;

    // Clear on grant or abandoned request; busy freezes; otherwise count up to the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (!req || gnt) begin
            r_wait_cnt <= '0;
        end else if (!busy && (r_wait_cnt < LP_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign ready = (r_wait_cnt == LP_WAIT);

endmodule

// File: rtl/ibus_responder.sv
// Instruction-bus responder: grants fetches after a programmable number of
// wait states, range/alignment-checks the address, reads a synchronous
// memory and returns exactly one response the cycle after each grant.
module ibus_responder
    import ibus_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = CPU_RESET_ADDR,
    parameter int          DEPTH_WORDS = IBUS_DEPTH_WORDS,
    parameter int          WAIT_CYCLES = 0
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_i,
    input  logic [31:0]                    addr_i,
    output logic                           gnt_o,
    output logic                           rvalid_o,
    output logic [31:0]                    rdata_o,
    output logic                           err_o,
    input  logic                           busy_i,
    output logic                           mem_en_o,
    output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr_o,
    input  logic [31:0]                    mem_rdata_i,
    input  logic                           cnt_clr_i,
    output logic [31:0]                    acc_cnt_o,
    output logic [31:0]                    err_cnt_o
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LP_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] LP_HI = LP_LO + (33'(DEPTH_WORDS) << 2);

    logic        w_ready;
    logic        w_gnt;
    logic        w_err;
    logic [32:0] w_addr_ext;

    logic        r_rvalid;
    logic        r_err;
    logic [31:0] r_acc_cnt;
    logic [31:0] r_err_cnt;

    ibus_wait_ctr #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_i),
        .busy  (busy_i),
        .gnt   (w_gnt),
        .ready (w_ready)
    );

    // Grant is combinational; held low while reset is asserted.
    assign w_gnt = rst_n & req_i & ~busy_i & w_ready;

    // 33-bit compare so a region ending at 4 GiB does not wrap.
    assign w_addr_ext = {1'b0, addr_i};
    assign w_err      = (addr_i[1:0] != 2'b00) | (w_addr_ext < LP_LO) | (w_addr_ext >= LP_HI);

    assign gnt_o      = w_gnt;
    assign mem_en_o   = w_gnt & ~w_err;
    // Only the word-index bits of the offset reach the memory.
    assign mem_addr_o = rst_n ? (addr_i[AW+1:2] - BASE_ADDR[AW+1:2]) : '0;

    // Response slot: one cycle after each grant, dropped by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
            r_err    <= w_gnt & w_err;
        end
    end

    // Memory data is valid exactly in the response cycle of a good grant.
    assign rvalid_o = r_rvalid;
    assign err_o    = r_rvalid & r_err;
    assign rdata_o  = (r_rvalid & ~r_err) ? mem_rdata_i : 32'h0;

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt <= '0;
            r_err_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_acc_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_gnt) begin
            r_acc_cnt <= sat_inc(r_acc_cnt);
            if (w_err) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end
        end
    end

    assign acc_cnt_o = r_acc_cnt;
    assign err_cnt_o = r_err_cnt;

endmodule
